adc_sample_packer: RTL and testbench
====================================

Name: adc_sample_packer

Overview:
- Parametrised ADC/GPIO capture front-end in the ADC clock domain. Feeds the write side of the async FIFO that drains to the HDMI data-acquisition core.
- Generalises the fixed {adc1, gpio, adc0} capture to configurable sample widths, four packing modes and programmable decimation.
- Drops words when the FIFO is not ready and counts each drop, instead of writing unconditionally.

Parameters:
ADC_WIDTH, 12, bits per ADC channel; legal range 8..16.
GPIO_WIDTH, 8, GPIO bits; must satisfy 2*ADC_WIDTH+GPIO_WIDTH <= 32 (elaboration error otherwise).
DECIM_WIDTH, 8, width of the decimation control.
OVF_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
clk  in  1  ADC sample clock; single clock domain.
rst  in  1  asynchronous, active-high reset.
enable  in  1  capture enable.
mode  in  2  0=DUAL_GPIO, 1=SINGLE_A, 2=SINGLE_B, 3=DUAL_16.
decim  in  DECIM_WIDTH  accept one sample every decim+1 cycles.
adc0_data  in  ADC_WIDTH  channel A sample.
adc1_data  in  ADC_WIDTH  channel B sample.
gpio_data  in  GPIO_WIDTH  auxiliary bits.
out_ready  in  1  FIFO can take a word (driven from not-almost-full).
out_data  out  32  packed word.
out_valid  out  1  one-cycle write strobe (FIFO winc).
ovf_count  out  OVF_CNT_WIDTH  dropped-word count; saturates at all-ones.
ovf_sticky  out  1  set on any drop.
ovf_clear  in  1  synchronous clear of ovf_count and ovf_sticky.

Behaviour:
- Reset (async, immediate): out_data=0, out_valid=0, ovf_count=0, ovf_sticky=0, active mode=0, decim counter=0, half-slot empty.
- Stage 1 registers adc0/adc1/gpio every cycle.
  - Take flag = enable AND decim counter==0.
  - On take, counter reloads to decim; otherwise it decrements while enable=1.
  - decim=0: every enabled cycle is taken. The first enabled cycle after reset or after an enable rise is always taken.
- Stage 2 packs and emits. Latency: data present at a taking edge k appears on out_data/out_valid after edge k+1.
- Packing, zero-extend to 16 bits where noted:
  - Mode 0: adc0 at [ADC_WIDTH-1:0], gpio directly above, adc1 above gpio, remaining MSBs zero. One word per take.
  - Mode 1: adc0 packed two per word. First take stored in the half-slot; second take emits {zext16(second), zext16(first)}.
  - Mode 2: as mode 1 using adc1.
  - Mode 3: {zext16(adc1), zext16(adc0)}. One word per take.
- Emit rule:
  - When a word completes and out_ready=1: out_valid=1 for exactly one cycle.
  - When out_ready=0: word discarded, out_valid stays 0, ovf_count+1 (saturating), ovf_sticky=1.
  - out_ready is only sampled at completion cycles.
- Overflow clear:
  - ovf_clear clears both overflow outputs next cycle.
  - If a drop coincides with the clear, the drop wins: count=1, sticky=1.
- Mode change (mode input differs from active mode on any cycle):
  - Active mode updates next cycle.
  - Pending half-slot is discarded, not emitted and not counted.
  - Decim counter reloads to 0, so the next enabled cycle is taken.
- decim change: takes effect at the next counter reload; no discard.
- enable falling: half-slot discarded, counter forced to 0, no words emitted while enable=0. A word already in stage 2 still emits.
- Reset mid-stream: all state lost, including a pending half-word; no partial word is emitted after release.

Test Plan:
1. mode0, decim0, ready=1, adc0=0x123, gpio=0xA5, adc1=0x456 -> out_data=0x456A5123, out_valid high every cycle, first strobe 2 edges after enable.
2. mode1, adc0 sequence 0x001,0x002,0x003,0x004 -> words 0x00020001 then 0x00040003, out_valid every second cycle.
3. mode3, decim=3, adc0=0x123, adc1=0x456 -> 0x04560123, one strobe per 4 cycles; change decim to 0 mid-run -> every cycle after the next reload.
4. mode0, out_ready=0 for 5 cycles -> 5 missing words, ovf_count=5, sticky=1; ovf_clear alone -> 0/0; ovf_clear coincident with a drop -> count=1, sticky=1; force 2^16+3 drops -> count=0xFFFF.
5. mode1, one sample captured, then mode->2 -> no emit and no overflow; next word holds two adc1 samples. Repeat with enable pulsed low mid-pair -> half discarded.
6. rst asserted mid-stream between clock edges -> out_valid=0 and ovf_count=0 immediately; after release with mode1, first word pairs the first two post-reset samples.

Source files
------------

// File: rtl/adc_sample_packer.sv
// ADC/GPIO capture front-end: registers samples, decimates, packs into 32-bit
// words and writes them to the acquisition FIFO, counting words dropped on backpressure.
module adc_sample_packer #(
    parameter int ADC_WIDTH     = 12,
    parameter int GPIO_WIDTH    = 8,
    parameter int DECIM_WIDTH   = 8,
    parameter int OVF_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic [DECIM_WIDTH-1:0]   decim,
    input  logic [ADC_WIDTH-1:0]     adc0_data,
    input  logic [ADC_WIDTH-1:0]     adc1_data,
    input  logic [GPIO_WIDTH-1:0]    gpio_data,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_valid,
    output logic [OVF_CNT_WIDTH-1:0] ovf_count,
    output logic                     ovf_sticky,
    input  logic                     ovf_clear
);

    typedef enum logic [1:0] {
        MODE_DUAL_GPIO = 2'd0,
        MODE_SINGLE_A  = 2'd1,
        MODE_SINGLE_B  = 2'd2,
        MODE_DUAL_16   = 2'd3
    } pack_mode_e;

    if (ADC_WIDTH < 8 || ADC_WIDTH > 16 || 2*ADC_WIDTH + GPIO_WIDTH > 32) begin : g_bad_params
        $error("adc_sample_packer: ADC_WIDTH must be 8..16 and 2*ADC_WIDTH+GPIO_WIDTH <= 32");
    end

    pack_mode_e             active_mode;
    logic [DECIM_WIDTH-1:0] decim_cnt;
    logic                   mode_change;
    logic                   flush;
    logic                   take;

    logic [ADC_WIDTH-1:0]   adc0_q;
    logic [ADC_WIDTH-1:0]   adc1_q;
    logic [GPIO_WIDTH-1:0]  gpio_q;
    logic                   take_q;

    logic [ADC_WIDTH-1:0]   half_data;
    logic                   half_valid;
    logic                   single_mode;
    logic [ADC_WIDTH-1:0]   single_sample;
    logic                   word_done;
    logic                   drop;
    logic [31:0]            word;

    // A mode change or a low enable suppresses the take and abandons any half-built word.
    assign mode_change = (mode != active_mode);
    assign flush       = mode_change || !enable;
    assign take        = enable && !mode_change && (decim_cnt == '0);

    // NOTE: the sample pipeline carries no reset; take_q gates every use of it,
    // so its contents are don't-care until the first take after reset.
    always_ff @(posedge clk) begin
        adc0_q <= adc0_data;
        adc1_q <= adc1_data;
        gpio_q <= gpio_data;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_mode <= MODE_DUAL_GPIO;
            decim_cnt   <= '0;
            take_q      <= 1'b0;
        end else begin
            active_mode <= pack_mode_e'(mode);
            take_q      <= take;
            if (flush)
                decim_cnt <= '0;
            else if (take)
                decim_cnt <= decim;
            else
                decim_cnt <= decim_cnt - DECIM_WIDTH'(1);
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        single_mode   = (active_mode == MODE_SINGLE_A) || (active_mode == MODE_SINGLE_B);
        single_sample = (active_mode == MODE_SINGLE_B) ? adc1_q : adc0_q;
        word          = '0;
        case (active_mode)
            MODE_DUAL_GPIO: word = 32'(adc0_q)
                                 | (32'(gpio_q) << ADC_WIDTH)
                                 | (32'(adc1_q) << (ADC_WIDTH + GPIO_WIDTH));
            MODE_DUAL_16:   word = {16'(adc1_q), 16'(adc0_q)};
            default:        word = {16'(single_sample), 16'(half_data)};
        endcase
        word_done = take_q && (!single_mode || half_valid);
        drop      = word_done && !out_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            half_data  <= '0;
            half_valid <= 1'b0;
            ovf_count  <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (word_done && out_ready) begin
                out_valid <= 1'b1;
                out_data  <= word;
            end

            if (flush) begin
                half_valid <= 1'b0;
            end else if (take_q && single_mode) begin
                half_valid <= !half_valid;
                if (!half_valid)
                    half_data <= single_sample;
            end

            // A drop in the same cycle as a clear restarts the count at one.
            if (drop) begin
                ovf_sticky <= 1'b1;
                if (ovf_clear)
                    ovf_count <= OVF_CNT_WIDTH'(1);
                else if (ovf_count != '1)
                    ovf_count <= ovf_count + OVF_CNT_WIDTH'(1);
            end else if (ovf_clear) begin
                ovf_count  <= '0;
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed testbench for adc_sample_packer: packing modes, decimation,
// overflow counting/clearing/saturation, mode/enable discards and mid-stream reset.
module tb_adc_sample_packer;

    localparam int ADC_W  = 12;
    localparam int GPIO_W = 8;
    localparam int DEC_W  = 8;
    localparam int OVF_W  = 16;

    logic              clk;
    logic              rst;
    logic              enable;
    logic [1:0]        mode;
    logic [DEC_W-1:0]  decim;
    logic [ADC_W-1:0]  adc0_data;
    logic [ADC_W-1:0]  adc1_data;
    logic [GPIO_W-1:0] gpio_data;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              out_valid;
    logic [OVF_W-1:0]  ovf_count;
    logic              ovf_sticky;
    logic              ovf_clear;

    int n_checks = 0;
    int n_errors = 0;

    adc_sample_packer #(
        .ADC_WIDTH(ADC_W), .GPIO_WIDTH(GPIO_W), .DECIM_WIDTH(DEC_W), .OVF_CNT_WIDTH(OVF_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .decim(decim),
        .adc0_data(adc0_data), .adc1_data(adc1_data), .gpio_data(gpio_data),
        .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
        .ovf_count(ovf_count), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are observed 1 ns after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup_mode(input logic [1:0] m);
        enable = 1'b0;
        mode   = m;
        decim  = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_out: valid=%b data=%h required valid=0 data=00000000", out_valid, out_data);
        end
        n_checks++;
        if (ovf_count !== 16'h0 || ovf_sticky !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ovf: count=%h sticky=%b required 0000/0", ovf_count, ovf_sticky);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_dual_gpio();
        logic [2:0] v;
        setup_mode(2'd0);
        adc0_data = 12'h123; gpio_data = 8'hA5; adc1_data = 12'h456;
        out_ready = 1'b1; enable = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL dual_gpio_latency1: valid=%b required 0", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h456A5123) begin
            n_errors++;
            $display("FAIL dual_gpio_word: valid=%b data=%h required 1/456a5123", out_valid, out_data);
        end
        for (int t = 0; t < 3; t++) begin
            tick();
            v[t] = out_valid;
        end
        n_checks++;
        if (v !== 3'b111) begin
            n_errors++; $display("FAIL dual_gpio_stream: valids=%b required 111", v);
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL dual_gpio_inflight: valid=%b required 1", out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL dual_gpio_stop: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_single_pack();
        setup_mode(2'd1);
        adc0_data = 12'h001; enable = 1'b1;
        tick();
        adc0_data = 12'h002;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_first_half: valid=%b required 0", out_valid);
        end
        adc0_data = 12'h003;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00020001) begin
            n_errors++;
            $display("FAIL single_word1: valid=%b data=%h required 1/00020001", out_valid, out_data);
        end
        adc0_data = 12'h004;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL single_gap: valid=%b required 0", out_valid);
        end
        enable = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00040003) begin
            n_errors++;
            $display("FAIL single_word2: valid=%b data=%h required 1/00040003", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_decim();
        logic [9:0] v;
        logic [7:0] w;
        setup_mode(2'd3);
        decim = 8'd3; adc0_data = 12'h123; adc1_data = 12'h456; out_ready = 1'b1;
        enable = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            v[t-1] = out_valid;
            if (t == 2) begin
                n_checks++;
                if (out_data !== 32'h04560123) begin
                    n_errors++; $display("FAIL decim_word: data=%h required 04560123", out_data);
                end
            end
        end
        n_checks++;
        if (v !== 10'h222) begin
            n_errors++; $display("FAIL decim3_pattern: valids=%b required 1000100010", v);
        end
        decim = 8'd0;
        for (int t = 0; t < 8; t++) begin
            tick();
            w[t] = out_valid;
        end
        n_checks++;
        if (w !== 8'hF8) begin
            n_errors++; $display("FAIL decim_change: valids=%b required 11111000", w);
        end
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_overflow();
        int n;
        setup_mode(2'd0);
        out_ready = 1'b1; enable = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        n = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            n += int'(out_valid);
        end
        n_checks++;
        if (n != 0) begin
            n_errors++; $display("FAIL ovf_no_strobe: strobes=%0d required 0", n);
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++; $display("FAIL ovf_resume: valid=%b required 1", out_valid);
        end
        n_checks++;
        if (ovf_count !== 16'd5 || ovf_sticky !== 1'b1) begin
            n_errors++; $display("FAIL ovf_count5: count=%0d sticky=%b required 5/1", ovf_count, ovf_sticky);
        end
        enable = 1'b0;
        tick();
        tick();
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        n_checks++;
        if (ovf_count !== 16'd0 || ovf_sticky !== 1'b0) begin
            n_errors++; $display("FAIL ovf_clear: count=%0d sticky=%b required 0/0", ovf_count, ovf_sticky);
        end

        out_ready = 1'b0; enable = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (ovf_count !== 16'd2) begin
            n_errors++; $display("FAIL ovf_pre_coincide: count=%0d required 2", ovf_count);
        end
        ovf_clear = 1'b1;
        tick();
        n_checks++;
        if (ovf_count !== 16'd1 || ovf_sticky !== 1'b1) begin
            n_errors++; $display("FAIL ovf_coincide: count=%0d sticky=%b required 1/1", ovf_count, ovf_sticky);
        end
        ovf_clear = 1'b0; enable = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0; out_ready = 1'b0; enable = 1'b1;
        for (int t = 0; t < 65540; t++) tick();
        n_checks++;
        if (ovf_count !== 16'hFFFF || ovf_sticky !== 1'b1) begin
            n_errors++; $display("FAIL ovf_saturate: count=%h sticky=%b required ffff/1", ovf_count, ovf_sticky);
        end
        enable = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        tick();
        n_checks++;
        if (ovf_count !== 16'd0) begin
            n_errors++; $display("FAIL ovf_final_clear: count=%h required 0000", ovf_count);
        end
    endtask

    task automatic test_mode_change();
        logic [3:0] v;
        setup_mode(2'd1);
        out_ready = 1'b1; adc0_data = 12'h011; adc1_data = 12'h0B0; enable = 1'b1;
        tick(); v[0] = out_valid;
        mode = 2'd2; adc1_data = 12'h0B1;
        tick(); v[1] = out_valid;
        tick(); v[2] = out_valid;
        adc1_data = 12'h0B2;
        tick(); v[3] = out_valid;
        enable = 1'b0;
        tick();
        n_checks++;
        if (v !== 4'b0000) begin
            n_errors++; $display("FAIL mode_change_no_emit: valids=%b required 0000", v);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00B200B1) begin
            n_errors++;
            $display("FAIL mode_change_word: valid=%b data=%h required 1/00b200b1", out_valid, out_data);
        end
        n_checks++;
        if (ovf_count !== 16'd0 || ovf_sticky !== 1'b0) begin
            n_errors++; $display("FAIL mode_change_ovf: count=%0d sticky=%b required 0/0", ovf_count, ovf_sticky);
        end
        tick();
    endtask

    task automatic test_enable_pulse();
        logic [3:0] v;
        setup_mode(2'd2);
        adc1_data = 12'h0C1; enable = 1'b1;
        tick(); v[0] = out_valid;
        enable = 1'b0;
        tick(); v[1] = out_valid;
        enable = 1'b1; adc1_data = 12'h0C2;
        tick(); v[2] = out_valid;
        adc1_data = 12'h0C3;
        tick(); v[3] = out_valid;
        enable = 1'b0;
        tick();
        n_checks++;
        if (v !== 4'b0000) begin
            n_errors++; $display("FAIL enable_pulse_no_emit: valids=%b required 0000", v);
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00C300C2) begin
            n_errors++;
            $display("FAIL enable_pulse_word: valid=%b data=%h required 1/00c300c2", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_reset_mid_stream();
        logic [4:0] v;
        setup_mode(2'd1);
        out_ready = 1'b0; adc0_data = 12'h0A0; enable = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || ovf_count !== 16'd1) begin
            n_errors++; $display("FAIL pre_reset_state: valid=%b count=%0d required 1/1", out_valid, ovf_count);
        end
        #3 rst = 1'b1;
        enable = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || ovf_count !== 16'd0 || ovf_sticky !== 1'b0 || out_data !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset: valid=%b count=%0d sticky=%b data=%h required 0/0/0/00000000",
                     out_valid, ovf_count, ovf_sticky, out_data);
        end
        tick();
        rst = 1'b0;
        tick(); v[0] = out_valid;
        tick(); v[1] = out_valid;
        adc0_data = 12'h0A1; enable = 1'b1;
        tick(); v[2] = out_valid;
        adc0_data = 12'h0A2;
        tick(); v[3] = out_valid;
        enable = 1'b0;
        tick(); v[4] = out_valid;
        n_checks++;
        if (v[3:0] !== 4'b0000) begin
            n_errors++; $display("FAIL post_reset_no_partial: valids=%b required 0000", v[3:0]);
        end
        n_checks++;
        if (v[4] !== 1'b1 || out_data !== 32'h00A200A1) begin
            n_errors++;
            $display("FAIL post_reset_word: valid=%b data=%h required 1/00a200a1", v[4], out_data);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'd0; decim = '0;
        adc0_data = '0; adc1_data = '0; gpio_data = '0;
        out_ready = 1'b1; ovf_clear = 1'b0;
        test_reset();
        test_dual_gpio();
        test_single_pack();
        test_decim();
        test_overflow();
        test_mode_change();
        test_enable_pulse();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
